// File: rtl/regfile_wr_arbiter.sv
// Two-requester write-port arbiter for the register file: one holding slot per requester,
// round-robin drain, pending-write scoreboard. Define RFARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 grant_id,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int NREG = 2**ADDR_W;

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [1:0]        full_reg;
  logic [ADDR_W-1:0] addr_reg [2];
  logic [DATA_W-1:0] data_reg [2];
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              grant_idx;
  logic              both_pick;
  logic [NREG-1:0]   slot_mask [2];
  logic [NREG-1:0]   issue_mask;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

`ifdef RFARB_FIXED_PRIO_EN
  assign both_pick = 1'b0;
`else
  logic ptr_reg;

  // Priority flips to the other requester after every grant, so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else if (|grant) begin
      ptr_reg <= ~grant_idx;
    end
  end

  assign both_pick = ptr_reg;
`endif

  always_comb begin
    grant = 2'b00;
    case (full_reg)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = both_pick ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign grant_idx  = grant[1];
  // A slot being drained this cycle may be refilled on the same edge.
  assign ready      = ~full_reg | grant;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          full_reg[gi] <= 1'b0;
          addr_reg[gi] <= '0;
          data_reg[gi] <= '0;
        end else if (req_valid[gi] && ready[gi]) begin
          full_reg[gi] <= 1'b1;
          addr_reg[gi] <= req_addr[gi];
          data_reg[gi] <= req_data[gi];
        end else if (grant[gi]) begin
          full_reg[gi] <= 1'b0;
        end
      end

      assign slot_mask[gi] = full_reg[gi] ? (NREG'(1) << addr_reg[gi]) : '0;
    end
  endgenerate

  // Address/data/id hold while idle so the gated write clock sees stable inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= 1'b0;
    end else if (|grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= addr_reg[grant_idx];
      rf_wdata <= data_reg[grant_idx];
      grant_id <= grant_idx;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign issue_mask = rf_we ? (NREG'(1) << rf_waddr) : '0;
  assign busy_mask  = slot_mask[0] | slot_mask[1] | issue_mask;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: stimulus queues expected writes, a monitor
// compares each rf_we cycle. Honors RFARB_FIXED_PRIO_EN for the contention expectations.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        grant_id;
  logic [3:0]  busy_mask;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        gid;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] rf_model [4];
  int          n_checks = 0;
  int          n_fail = 0;
  int          k0, k1;
  logic        s_r0, s_r1, s_we;
  logic [3:0]  s_busy;
  logic        acc0, acc1;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] d, input logic g);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.gid  = g;
    exp_q.push_back(e);
  endtask

  // Sample in the middle of the cycle, then step past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    s_r0   = req0_ready;
    s_r1   = req1_ready;
    s_we   = rf_we;
    s_busy = busy_mask;
    @(posedge clk);
    #1;
    acc0 = req0_valid && s_r0 && !reset;
    acc1 = req1_valid && s_r1 && !reset;
  endtask

  task automatic upd();
    if (acc0) begin
      k0++;
      if (k0 == 4) req0_valid = 1'b0;
      else req0_data = 32'hA000_0000 + 32'(k0);
    end
    if (acc1) begin
      k1++;
      if (k1 == 4) req1_valid = 1'b0;
      else req1_data = 32'hB000_0000 + 32'(k1);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h grant %0d, required no write",
                 rf_waddr, rf_wdata, grant_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(mon_e.addr));
        check("wr_data", rf_wdata, mon_e.data);
        check("wr_grant_id", 32'(grant_id), 32'(mon_e.gid));
        $display("write reg %0d = %h from req %0d", rf_waddr, rf_wdata, grant_id);
        rf_model[rf_waddr] <= rf_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int iter;
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 32'hA000_0000;
    req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 32'hB000_0000;
    k0 = 0; k1 = 0;
    @(posedge clk); #1;
    cycle();
    cycle();
    check("reset_rf_we", 32'(s_we), 32'd0);
    check("reset_busy_mask", 32'(s_busy), 32'd0);
    check("reset_ready0", 32'(s_r0), 32'd1);
    check("reset_ready1", 32'(s_r1), 32'd1);

`ifdef RFARB_FIXED_PRIO_EN
    for (int n = 0; n < 4; n++) push(2'd1, 32'hA000_0000 + 32'(n), 1'b0);
    for (int n = 0; n < 4; n++) push(2'd3, 32'hB000_0000 + 32'(n), 1'b1);
`else
    for (int n = 0; n < 4; n++) begin
      push(2'd1, 32'hA000_0000 + 32'(n), 1'b0);
      push(2'd3, 32'hB000_0000 + 32'(n), 1'b1);
    end
`endif

    reset = 1'b0;
    cycle();
    check("accept_both_after_reset", 32'({acc0, acc1}), 32'd3);
    upd();
    iter = 0;
    while ((req0_valid || req1_valid) && iter < 40) begin
      cycle();
`ifdef RFARB_FIXED_PRIO_EN
      if (iter < 3) check("fixed_ready1_low", 32'(s_r1), 32'd0);
`else
      if (iter < 4) begin
        check("contend_ready0", 32'(s_r0), 32'(iter % 2 == 0));
        check("contend_ready1", 32'(s_r1), 32'(iter % 2 == 1));
      end
      if (iter >= 1) check("contend_rf_we", 32'(s_we), 32'd1);
`endif
      upd();
      iter++;
    end
    check("contend_loop_bound", 32'(iter < 40), 32'd1);
    repeat (6) cycle();
    check("contend_drained", 32'(exp_q.size()), 32'd0);

    req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 32'hDEAD_BEEF;
    push(2'd2, 32'hDEAD_BEEF, 1'b0);
    cycle();
    check("single_accept", 32'(acc0), 32'd1);
    req0_valid = 1'b0;
    cycle();
    check("single_busy_slot", 32'(s_busy), 32'h4);
    check("single_we_not_yet", 32'(s_we), 32'd0);
    cycle();
    check("single_we", 32'(s_we), 32'd1);
    check("single_busy_issue", 32'(s_busy), 32'h4);
    cycle();
    check("single_busy_retired", 32'(s_busy), 32'd0);

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 32'h22;
    push(2'd0, 32'h11, 1'b0);
    push(2'd0, 32'h22, 1'b1);
    cycle();
    check("conflict_accept", 32'({acc0, acc1}), 32'd3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cycle();
    check("conflict_final_reg0", rf_model[0], 32'h22);

    req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 32'h33;
    push(2'd3, 32'h33, 1'b0);
    cycle();
    req0_valid = 1'b0;
    repeat (3) cycle();
    req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 32'h55;
    req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 32'h66;
    cycle();
    check("midrst_accept", 32'({acc0, acc1}), 32'd3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    cycle();
    check("midrst_busy_before", 32'(s_busy), 32'h6);
    reset = 1'b0;
    cycle();
    check("midrst_rf_we", 32'(s_we), 32'd0);
    check("midrst_busy_after", 32'(s_busy), 32'd0);

    req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 32'h77;
    req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 32'h88;
    push(2'd1, 32'h77, 1'b0);
    push(2'd2, 32'h88, 1'b1);
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cycle();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
